// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the mac_dot dot-product engine:
//   - state_e   : engine control states (IDLE / RUN / DRAIN)
//   - sat_e     : outcome of the output saturation check
//   - acc_width : accumulator width derivation, 2*WIDTH - FRAC + GUARD
//   - sat_check : classifies a wide signed value against the WIDTH-bit range
//   - ONE       : Q-format 1.0 for the default fractional width
// No ports (package).
// -----------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_e;

    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 24;
    localparam int GUARD_DEF = 8;

    // Q-format 1.0 for the default fractional width.
    localparam logic [31:0] ONE = 32'd1 << FRAC_DEF;

    // Wide working type for range checks; must exceed any accumulator width in use.
    localparam int SAT_W = 128;
    typedef logic signed [SAT_W-1:0] wide_t;

    // Per-lane product keeps 2*WIDTH-FRAC bits after the shift; GUARD bits
    // absorb growth from summing lanes and beats.
    function automatic int acc_width(input int width, input int frac, input int guard);
        return 2 * width - frac + guard;
    endfunction

    localparam int ACC_W_DEF = acc_width(WIDTH_DEF, FRAC_DEF, GUARD_DEF);

    // Decide whether a signed value fits in 'width' bits or must clamp high/low.
    function automatic sat_e sat_check(input wide_t a, input int width);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1'b1) <<< (width - 1)) - wide_t'(1'b1);
        lo = ~hi;
        if (a > hi) begin
            return SAT_POS;
        end else if (a < lo) begin
            return SAT_NEG;
        end else begin
            return SAT_NONE;
        end
    endfunction

endpackage

// File: rtl/mac_lane_mul.sv
// -----------------------------------------------------------------------------
// mac_lane_mul
// One multiplier lane: full-precision signed product of two WIDTH-bit
// operands, arithmetic shift right by FRAC (floor toward -inf), registered
// and sign-extended to ACC_W. When i_en is low the register loads zero so a
// bubble contributes nothing downstream.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   i_en  in   a beat is being accepted this cycle
//   i_x   in   signed operand x
//   i_m   in   signed operand m
//   o_p   out  registered shifted product (ACC_W bits, signed)
// -----------------------------------------------------------------------------
module mac_lane_mul
    import mac_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic signed [WIDTH-1:0] i_x,
    input  logic signed [WIDTH-1:0] i_m,
    output logic signed [ACC_W-1:0] o_p
);

    typedef logic signed [2*WIDTH-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]   acc_t;

    prod_t prod_s;
    acc_t  p_d;
    acc_t  p_q;

    // Full product, floor-shifted and resized; zero on bubbles.
    always_comb begin
        prod_s = prod_t'(i_x) * prod_t'(i_m);
        if (i_en) begin
            p_d = acc_t'(prod_s >>> FRAC);
        end else begin
            p_d = '0;
        end
    end

    // Product register.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign o_p = p_q;

endmodule

// File: rtl/mac_dot.sv
// -----------------------------------------------------------------------------
// mac_dot
// Multi-lane fixed-point dot-product engine. Each accepted beat multiplies
// LANES operand pairs, the lane products are summed and accumulated over
// i_len beats on top of i_bias, and the total is saturated to WIDTH bits.
// Ports:
//   clk, rst     clock (rising) and synchronous active-high reset
//   i_start      start a job (only honoured in IDLE)
//   i_len        beat count, sampled with i_start
//   i_bias       initial accumulator value, sampled with i_start
//   i_valid      beat present on i_x / i_m
//   i_x, i_m     LANES packed operands, lane k at [k*WIDTH +: WIDTH]
//   o_ready      beat is accepted when i_valid && o_ready
//   o_busy       high from start acceptance until the result strobe
//   o_valid      one-cycle result strobe
//   o, o_ovf     saturated result and saturation flag, held until next strobe
// Pipeline: beat sampled at edge n -> lane products at n, accumulate at n+1,
// result registered at n+2.
// -----------------------------------------------------------------------------
module mac_dot
    import mac_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int LANES = 4,
    parameter int LEN_W = 8,
    parameter int GUARD = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [LEN_W-1:0]       i_len,
    input  logic [WIDTH-1:0]       i_bias,
    input  logic                   i_valid,
    input  logic [LANES*WIDTH-1:0] i_x,
    input  logic [LANES*WIDTH-1:0] i_m,
    output logic                   o_ready,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [WIDTH-1:0]       o,
    output logic                   o_ovf
);

    localparam int ACC_W = acc_width(WIDTH, FRAC, GUARD);
    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef logic signed [ACC_W-1:0] acc_t;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    acc_t             acc_q, acc_d;
    logic             beat_v_q, beat_v_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic             beat_s;
    acc_t             lane_p [LANES];
    acc_t             sum_s;
    sat_e             sat_s;

    // ready_q is only ever set while in RUN; the state term keeps the accept
    // condition self-contained.
    assign beat_s = i_valid && ready_q && (state_q == ST_RUN);

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            mac_lane_mul #(
                .WIDTH (WIDTH),
                .FRAC  (FRAC),
                .ACC_W (ACC_W)
            ) u_mul (
                .clk  (clk),
                .rst  (rst),
                .i_en (beat_s),
                .i_x  (i_x[k*WIDTH +: WIDTH]),
                .i_m  (i_m[k*WIDTH +: WIDTH]),
                .o_p  (lane_p[k])
            );
        end
    endgenerate

    // Binary adder tree over the lane products: leaves at [LANES..2*LANES-1],
    // node i sums children 2i and 2i+1, root at index 1.
    always_comb begin
        acc_t t [2*LANES];
        t[0] = '0;
        for (int i = 0; i < LANES; i++) begin
            t[LANES + i] = lane_p[i];
        end
        for (int i = LANES - 1; i >= 1; i--) begin
            t[i] = t[2*i] + t[2*i + 1];
        end
        sum_s = t[1];
    end

    // Control FSM, accumulator and output next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_v_d = beat_s;
        o_d      = o_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        busy_d   = busy_q;
        ready_d  = ready_q;
        sat_s    = sat_check(wide_t'(acc_q), WIDTH);

        // Lane registers hold zero on bubbles, so gating on the valid bit is
        // only a power/clarity measure, not a correctness one.
        if (beat_v_q) begin
            acc_d = acc_q + sum_s;
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    cnt_d  = i_len;
                    acc_d  = {{(ACC_W-WIDTH){i_bias[WIDTH-1]}}, i_bias};
                    busy_d = 1'b1;
                    if (i_len != '0) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        ready_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (beat_s) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DRAIN;
                        ready_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Once the product stage is empty the accumulator is final.
                if (!beat_v_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    case (sat_s)
                        SAT_POS: begin
                            o_d   = {1'b0, {(WIDTH-1){1'b1}}};
                            ovf_d = 1'b1;
                        end
                        SAT_NEG: begin
                            o_d   = {1'b1, {(WIDTH-1){1'b0}}};
                            ovf_d = 1'b1;
                        end
                        default: begin
                            o_d   = acc_q[WIDTH-1:0];
                            ovf_d = 1'b0;
                        end
                    endcase
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            beat_v_q <= 1'b0;
            o_q      <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            beat_v_q <= beat_v_d;
            o_q      <= o_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o       = o_q;
    assign o_ovf   = ovf_q;

endmodule

// File: doc/mac_dot.md
# mac_dot

Parametrised multi-lane fixed-point dot-product engine: successor to the single-lane multiply-accumulate used by the LSTM gate datapath. Each accepted beat multiplies LANES operand pairs in parallel, sums them through an adder tree, and accumulates the sum over a programmable number of beats, starting from a bias. The result is saturated to WIDTH bits and returned with a one-cycle valid pulse. It sits between the weight/activation buffers and the gate activation units.

## Interface

- WIDTH, 32, operand/result width, signed two's complement
- FRAC, 24, fractional bits (Q(WIDTH-FRAC).FRAC)
- LANES, 4, parallel multiplier lanes, power of two ≥1
- LEN_W, 8, width of beat-count input
- GUARD, 8, accumulator guard bits
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- i_start  input  1  start a new dot product (honoured only in IDLE)
- i_len  input  LEN_W  number of beats, sampled with i_start
- i_bias  input  WIDTH  initial accumulator value, sampled with i_start
- i_valid  input  1  beat present on i_x/i_m
- i_x  input  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- i_m  input  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- o_ready  output  1  engine accepts a beat this cycle
- o_busy  output  1  high from start acceptance until o_valid
- o_valid  output  1  one-cycle result strobe
- o  output  WIDTH  saturated result, held until next o_valid
- o_ovf  output  1  result was saturated, held with o

## Operation

- States: IDLE, RUN, DRAIN.
- IDLE: i_start=1 → latch i_len into remaining-beat counter, load accumulator with i_bias sign-extended; if i_len≠0 → RUN, else → DRAIN.
- RUN: o_ready=1. Beat accepted when i_valid && o_ready; counter decrements; at last beat → DRAIN. i_valid=0 inserts a bubble (zero contribution); there is no timeout.
- DRAIN: waits until the pipeline valid bits are empty, then registers the result, pulses o_valid and returns to IDLE.
- i_start is ignored outside IDLE. i_start in the o_valid cycle is accepted, because the state is already IDLE.
- Lane product: full 2*WIDTH signed product, arithmetic shift right by FRAC (floor toward −∞).
- Lane sum and accumulator width: ACC_W = 2*WIDTH−FRAC+GUARD. The accumulator wraps modulo 2^ACC_W; callers keep len*LANES ≤ 2^GUARD.
- Output saturation: accumulator > 2^(WIDTH−1)−1 → 0x7FF…F with o_ovf=1; < −2^(WIDTH−1) → 0x800…0 with o_ovf=1; otherwise truncate to WIDTH bits with o_ovf=0.

## Timing

- Reset values: o=0, o_ovf=0, o_valid=0, o_ready=0, o_busy=0, state IDLE, accumulator 0, pipeline valid bits 0.
- Start accepted at edge s: o_busy=1 and o_ready=1 from cycle s onward, so the first beat can be accepted at edge s+1.
- Pipeline: beat sampled at edge n → product registers at n; adder tree plus accumulate at n+1; o, o_ovf and o_valid registered at n+2. o_valid is high for exactly cycle n+2..n+3, and o_busy falls in the same cycle.
- i_len=0: o=sat(i_bias), with o_valid registered at edge s+1.
- rst mid-operation aborts the computation: no o_valid, all outputs return to reset values on the next edge, and no residue carries into the next job.

## Structure

- Shared package mac_pkg holds:
  - state encoding (IDLE/RUN/DRAIN)
  - ACC_W derivation constant
  - saturate-to-WIDTH function
  - Q-format constant ONE = 1<<FRAC
- Sub-module mac_lane_mul: one lane's registered signed multiply with floor shift. It is instantiated LANES times via generate. The adder tree is inline.

## Test plan

1. LANES=4, len=1, all x=0x01000000 (1.0), all m=0x00800000 (0.5), bias 0 → o=0x02000000, o_ovf=0, o_valid at edge n+2.
2. len=3, x=1.0, m=1.0, bias=0x00400000, i_valid deasserted for 2 cycles between beats → o=0x0C400000, identical to the gapless run; o_ready stays high throughout RUN.
3. len=1, x=m=0x7F000000 → o=0x7FFFFFFF, o_ovf=1. Then x=0x81000000, m=0x7F000000 → o=0x80000000, o_ovf=1.
4. Floor rounding: all lanes x=0xFFFFFFFF, m=0x00800000, len=1 → o=0xFFFFFFFC.
5. len=0, bias=0xFE800000 → o=0xFE800000 at edge s+1. A second i_start during the following RUN is ignored (no extra o_valid).
6. rst asserted after 2 of 4 beats → no o_valid, outputs zero. A new start (len=1, x=m=1.0) then gives o=0x04000000.
